// File: rtl/od_pad_pkg.sv
// Shared types and defaults for the open-drain pad transmitter.
// Holds the FSM state enum and the default parameter constants.
package od_pad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SLOT,
    DONE
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BIT_CYC    = 32;
  localparam int DEF_SETTLE_CYC = 16;

endpackage

// File: rtl/od_bit_timer.sv
// Slot counter and bit counter for od_pad_tx.
// Ports: clk, rst, run (in SLOT); sample/slot_end strobes,
// last (final bit), bit_pos (data index being sent, MSB first).
module od_bit_timer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYC    = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  output logic                      sample,
  output logic                      slot_end,
  output logic                      last,
  output logic [$clog2(DATA_W)-1:0] bit_pos
);

  localparam int CW = $clog2(BIT_CYC);
  localparam int IW = $clog2(DATA_W);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_SMP  = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_W - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] bit_cnt;

  // Held at zero outside SLOT, so a new transfer starts clean.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      bit_cnt <= bit_cnt + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sample   = run && (cnt == CNT_SMP);
  assign slot_end = run && (cnt == CNT_LAST);
  assign last     = (bit_cnt == BIT_LAST);
  assign bit_pos  = BIT_LAST - bit_cnt;

endmodule

// File: rtl/od_pad_tx.sv
// Open-drain (wired-AND) serial transmitter driving one pad, MSB first.
// Ports: clk, rst, tx_valid/tx_ready/tx_data request; done, arb_lost,
// fault, rx_data result; pad_do, pad_oen, pad_ren, pad_ie, pad_di pad.
// Macro OD_PAD_TX_READBACK_EN enables readback, arbitration and fault.
module od_pad_tx
  import od_pad_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BIT_CYC    = DEF_BIT_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              done,
  output logic              arb_lost,
  output logic              fault,
  output logic [DATA_W-1:0] rx_data,
  output logic              pad_do,
  output logic              pad_oen,
  output logic              pad_ren,
  output logic              pad_ie,
  input  logic              pad_di
);

  localparam int IW = $clog2(DATA_W);

  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] data;
  logic [IW-1:0]     pos;
  logic              sample;
  logic              slot_end;
  logic              last;
  logic              run;
  logic              accept;
  logic              cur;
  logic              abort;

  od_bit_timer #(
    .DATA_W    (DATA_W),
    .BIT_CYC   (BIT_CYC),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .sample  (sample),
    .slot_end(slot_end),
    .last    (last),
    .bit_pos (pos)
  );

  assign run      = (state == SLOT);
  assign tx_ready = (state == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign cur      = data[pos];
  assign done     = (state == DONE);

  // A 1 bit is sent by releasing the pad; pad_do mirrors oen.
  assign pad_oen = run ? cur : 1'b1;
  assign pad_do  = pad_oen;
  assign pad_ren = 1'b0;

`ifdef OD_PAD_TX_READBACK_EN
  assign pad_ie = sample;
  // Someone else holds the line low while we released it.
  assign abort  = sample && cur && !pad_di;
`else
  logic unused_rb;
  assign unused_rb = pad_di ^ sample;
  assign pad_ie    = 1'b0;
  assign abort     = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = SLOT;
      SLOT: if (abort || (slot_end && last)) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data     <= '0;
      rx_data  <= '0;
      arb_lost <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        data     <= tx_data;
        rx_data  <= '0;
        arb_lost <= 1'b0;
        fault    <= 1'b0;
      end
`ifdef OD_PAD_TX_READBACK_EN
      if (sample) rx_data[pos] <= pad_di;
      if (abort) arb_lost <= 1'b1;
      if (sample && !cur && pad_di) fault <= 1'b1;
`else
      if (run && nxt == DONE) rx_data <= data;
`endif
    end
  end

endmodule

// File: tb/tb_od_pad_tx.sv
// Randomized self-checking bench for od_pad_tx (8 bits, 8-cycle slots).
// Expectations follow OD_PAD_TX_READBACK_EN the same way as the design.
module tb_od_pad_tx;

`ifdef OD_PAD_TX_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       done;
  logic       arb_lost;
  logic       fault;
  logic [7:0] rx_data;
  logic       pad_do;
  logic       pad_oen;
  logic       pad_ren;
  logic       pad_ie;
  logic       pad_di;

  int checks = 0;
  int errors = 0;

  od_pad_tx #(
    .DATA_W    (8),
    .BIT_CYC   (8),
    .SETTLE_CYC(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .done    (done),
    .arb_lost(arb_lost),
    .fault   (fault),
    .rx_data (rx_data),
    .pad_do  (pad_do),
    .pad_oen (pad_oen),
    .pad_ren (pad_ren),
    .pad_ie  (pad_ie),
    .pad_di  (pad_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Line seen by the pad in cycle c after acceptance.
  // 0: follows our own drive, 1: forced low from cycle fc,
  // 2: stuck high, 3: stuck low.
  function automatic logic di_model(input int mode, input int fc,
                                    input int c, input logic oen);
    case (mode)
      0: return oen;
      1: return (c >= fc) ? 1'b0 : oen;
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Cycle 0 is the acceptance cycle; bit k occupies cycles 1+8k..8+8k,
  // sampled in cycle 3+8k.
  task automatic xfer(input logic [7:0] w, input int mode, input int fc,
                      input bit hold_valid);
    int         dc;
    logic [7:0] erx;
    logic       earb;
    logic       eflt;
    logic       eoen;
    logic       eie;
    dc   = 65;
    erx  = RB ? 8'h00 : w;
    earb = 1'b0;
    eflt = 1'b0;
    if (RB) begin
      for (int k = 0; k < 8; k++) begin
        if (dc == 65) begin
          int   b;
          int   s;
          logic d;
          b = 7 - k;
          s = 3 + 8 * k;
          d = di_model(mode, fc, s, w[b]);
          erx[b] = d;
          if (w[b] && !d) begin
            earb = 1'b1;
            dc   = s + 1;
          end else if (!w[b] && d) begin
            eflt = 1'b1;
          end
        end
      end
    end
    check("ready_idle", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = w;
    pad_di   = di_model(mode, fc, 0, pad_oen);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (!hold_valid) tx_valid = 1'b0;
      tx_data = 8'($urandom);
      eoen = (c < dc) ? w[7 - (c - 1) / 8] : 1'b1;
      eie  = RB && (c < dc) && ((c - 1) % 8 == 2);
      check("pad_oen", pad_oen, eoen);
      check("pad_do", pad_do, eoen);
      check("pad_ie", pad_ie, eie);
      check("pad_ren", pad_ren, 1'b0);
      check("ready_busy", tx_ready, 1'b0);
      check("done", done, c == dc);
      pad_di = di_model(mode, fc, c, pad_oen);
    end
    check("rx_data", rx_data, erx);
    check("arb_lost", arb_lost, earb);
    check("fault", fault, eflt);
    @(negedge clk);
    check("done_off", done, 1'b0);
    check("ready_gap", tx_ready, 1'b1);
    check("rx_hold", rx_data, erx);
    check("arb_hold", arb_lost, earb);
    check("fault_hold", fault, eflt);
  endtask

  initial begin
    int n_done;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    pad_di   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_oen", pad_oen, 1'b1);
    check("rst_do", pad_do, 1'b1);
    check("rst_ren", pad_ren, 1'b0);
    check("rst_ie", pad_ie, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_arb", arb_lost, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_rx", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    xfer(8'hA5, 0, 0, 1'b0);
    xfer(8'hFF, 1, 10, 1'b0);
    xfer(8'h00, 2, 0, 1'b0);
    xfer(8'h3C, 3, 0, 1'b0);

    xfer(8'h5A, 0, 0, 1'b1);
    xfer(8'hC3, 0, 0, 1'b1);
    xfer(8'h96, 2, 0, 1'b1);
    tx_valid = 1'b0;

    for (int i = 0; i < 14; i++) begin
      xfer(8'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(1, 64)), bit'($urandom_range(0, 1)));
    end
    tx_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a transfer.
    check("ready_pre_rst", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'hB7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      pad_di   = pad_oen;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_oen", pad_oen, 1'b1);
    check("mid_rst_do", pad_do, 1'b1);
    check("mid_rst_ie", pad_ie, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b0);
    check("mid_rst_rx", rx_data, 8'h00);
    check("mid_rst_arb", arb_lost, 1'b0);
    check("mid_rst_fault", fault, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", tx_ready, 1'b1);
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/od_pad_tx.md
OD_PAD_TX -- requirements
Module: od_pad_tx

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer.
REQ-002 Parameter BIT_CYC, default 32: clock cycles per bit slot.
REQ-003 Parameter SETTLE_CYC, default 16: cycles from slot start to DI sample; legal range 1 ≤ SETTLE_CYC < BIT_CYC.
REQ-004 clk  in  1  the block's only clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tx_valid  in  1  a transfer request is present.
REQ-007 tx_ready  out  1  the block accepts a request this cycle.
REQ-008 tx_data  in  DATA_W  transmit word, sent MSB first.
REQ-009 done  out  1  one-cycle pulse when a transfer ends, completed or aborted.
REQ-010 arb_lost  out  1  valid with done: a released bit was read back low.
REQ-011 fault  out  1  valid with done: a driven-low bit was read back high.
REQ-012 rx_data  out  DATA_W  readback word, valid with done.
REQ-013 pad_do  out  1  pad data; always 0 when driving.
REQ-014 pad_oen  out  1  pad output enable, active-low; 1 releases the pad.
REQ-015 pad_ren  out  1  pull-up enable, active-low; held 0 (pull-up on) at all times.
REQ-016 pad_ie  out  1  pad input enable; 1 only in the sample cycle.
REQ-017 pad_di  in  1  pad readback, synchronous to clk (synchronised externally).

Function
REQ-018 Line behaviour: open-drain, wired-AND. Bit 0 SHALL be sent as pad_do=0, pad_oen=0. Bit 1 SHALL be sent as pad_do=1, pad_oen=1, so the pull-up raises the line.
REQ-019 FSM states and transitions:
- IDLE -> SLOT on tx_valid && tx_ready.
- SLOT -> SLOT at the next bit when the slot ends.
- SLOT -> DONE after the last bit, or on abort.
- DONE -> IDLE unconditionally after one cycle.
REQ-020 tx_ready SHALL be 1 only in IDLE. tx_valid in any other state SHALL be ignored.
REQ-021 tx_data SHALL be captured on acceptance. Pad outputs for the MSB SHALL change on the next clock edge.
REQ-022 Slot counter: counts 0..BIT_CYC-1 and wraps to 0 when it advances the bit index.
REQ-023 Sampling: pad_ie=1 and pad_di is sampled into rx_data when the counter equals SETTLE_CYC-1. The sampled bit lands at the position being sent.
REQ-024 A sample of 0 during a released bit SHALL abort. The block sets arb_lost, releases the pad on the next edge, and enters DONE. Unsent rx_data bits read 0.
REQ-025 A sample of 1 during a driven-low bit SHALL set fault. The transfer continues (no abort).
REQ-026 A complete transfer SHALL take DATA_W*BIT_CYC cycles in SLOT, plus 1 cycle in DONE.
REQ-027 arb_lost, fault and rx_data SHALL hold their values until the next acceptance. Both flags clear on acceptance.
REQ-028 If arb_lost and fault would both be set in the same slot, only arb_lost SHALL be set (the two cannot coexist within one bit; the rule is for completeness).

Reset
REQ-029 In reset, and on the first edge after rst rises mid-transfer, outputs SHALL be:
- state = IDLE, pad_oen=1, pad_do=1, pad_ren=0, pad_ie=0;
- tx_ready=0 while rst=1, then 1 on the first cycle after release;
- done=0, arb_lost=0, fault=0, rx_data=0, counters 0.
REQ-030 A transfer interrupted by reset SHALL NOT generate done.

Configuration
REQ-031 With macro OD_PAD_TX_READBACK_EN defined, the block SHALL implement REQ-023 to REQ-025.
REQ-032 Without OD_PAD_TX_READBACK_EN:
- pad_ie is held 0 and pad_di is unused;
- arb_lost and fault are held 0;
- rx_data returns the captured tx_data at done;
- timing is identical.

Structure
REQ-033 Shared package od_pad_pkg SHALL hold the FSM state enum (IDLE, SLOT, DONE) and the default parameter constants.
REQ-034 The slot counter and bit index SHALL live in sub-module od_bit_timer. It outputs a sample strobe, a slot-end strobe and a last-bit flag.

Verification (DATA_W=8, BIT_CYC=8, SETTLE_CYC=3, macro defined unless stated)
REQ-035 Send 0xA5 with pad_di = the driven line (pad_oen ? 1 : 0). Required response:
- pad_oen sequence per 8-cycle slot is 1,0,1,0,0,1,0,1;
- done occurs 65 cycles after acceptance;
- rx_data=0xA5, arb_lost=0, fault=0.
REQ-036 Send 0xFF with pad_di forced 0 from cycle 10 after acceptance. Required response:
- abort in bit 1 with arb_lost=1;
- pad_oen=1 on the next edge;
- done occurs in the cycle after abort, and rx_data=0x80.
REQ-037 Send 0x00 with pad_di stuck 1. Required response: full 65-cycle transfer, fault=1, arb_lost=0, rx_data=0xFF.
REQ-038 Pulse rst at cycle 20 of a transfer. Required response:
- pad_oen=1 on the next edge;
- no done pulse;
- tx_ready=1 on the first cycle after rst falls.
REQ-039 Assert tx_valid continuously with changing tx_data. Required response:
- each transfer sends only the word captured at acceptance;
- exactly one IDLE cycle separates consecutive transfers.
REQ-040 Without the macro, send 0x3C with pad_di=0. Required response: pad_ie never 1, arb_lost=0, rx_data=0x3C, done at cycle 65.
